// File: rtl/stump_control_fsm_if.sv
// Stump control bus: instruction/flag/memory-handshake inputs to the
// sequencer, and every datapath enable and operand select it drives.
interface stump_control_fsm_if;
  logic [15:0] ir;
  logic [3:0]  cc;
  logic        mem_ready;
  logic [1:0]  state;
  logic        ir_en;
  logic        pc_inc;
  logic        reg_write;
  logic [2:0]  dest;
  logic [2:0]  srcA;
  logic [2:0]  srcB;
  logic [1:0]  shift_op;
  logic        opB_imm;
  logic [15:0] imm16;
  logic [2:0]  alu_func;
  logic        cc_en;
  logic        mem_ren;
  logic        mem_wen;
  logic        addr_sel;

  // Sequencer side: consumes IR/CC/handshake, drives the datapath controls.
  modport master (
    input  ir, cc, mem_ready,
    output state, ir_en, pc_inc, reg_write, dest, srcA, srcB, shift_op,
           opB_imm, imm16, alu_func, cc_en, mem_ren, mem_wen, addr_sel
  );

  // Datapath side: supplies IR/CC/handshake, obeys the controls.
  modport slave (
    output ir, cc, mem_ready,
    input  state, ir_en, pc_inc, reg_write, dest, srcA, srcB, shift_op,
           opB_imm, imm16, alu_func, cc_en, mem_ren, mem_wen, addr_sel
  );
endinterface

// File: rtl/stump_control_fsm.sv
// Stump instruction sequencer. FETCH -> EXECUTE -> (MEMORY) -> FETCH.
// Only the state is registered; every control output is decoded
// combinationally from state, ir, cc and mem_ready. Write strobes are
// forced low while rst_n is asserted so a reset mid-access never commits.
module stump_control_fsm #(
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  input logic                 clk,
  input logic                 rst_n,
  stump_control_fsm_if.master bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    MEMORY  = 2'b10,
    UNUSED  = 2'b11
  } state_t;

  localparam logic [2:0] OP_MEM    = 3'b110;
  localparam logic [2:0] OP_BRANCH = 3'b111;

  state_t state_q;
  state_t state_d;

  // Instruction fields
  logic [2:0] op;
  logic       is_imm;
  logic       s_bit;
  logic [3:0] cond;
  logic       cc_n, cc_z, cc_v, cc_c;

  assign op     = bus.ir[15:13];
  assign is_imm = bus.ir[12];
  assign s_bit  = bus.ir[11];
  assign cond   = bus.ir[11:8];
  assign {cc_n, cc_z, cc_v, cc_c} = bus.cc;

  // Decoded operand fields, shared by EXECUTE and MEMORY
  logic [2:0]  dec_dest;
  logic [2:0]  dec_srca;
  logic [2:0]  dec_srcb;
  logic [1:0]  dec_shift;
  logic        dec_opb_imm;
  logic [15:0] dec_imm16;
  logic        cond_true;

  // Operand decode: branch, immediate and register forms
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    dec_dest    = bus.ir[10:8];
    dec_srca    = bus.ir[7:5];
    dec_srcb    = 3'd0;
    dec_shift   = 2'b00;
    dec_opb_imm = 1'b0;
    dec_imm16   = 16'h0000;
    if (op == OP_BRANCH) begin
      dec_dest    = 3'd7;
      dec_srca    = 3'd7;
      dec_opb_imm = 1'b1;
      dec_imm16   = {{8{bus.ir[7]}}, bus.ir[7:0]};
    end else if (is_imm) begin
      dec_opb_imm = 1'b1;
      dec_imm16   = {{11{bus.ir[4]}}, bus.ir[4:0]};
    end else begin
      dec_srcb  = bus.ir[4:2];
      dec_shift = bus.ir[1:0];
    end
  end

  // Branch condition evaluation against {N,Z,V,C}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = 1'b0;
      4'h2: cond_true = ~cc_c & ~cc_z;
      4'h3: cond_true = cc_c | cc_z;
      4'h4: cond_true = ~cc_c;
      4'h5: cond_true = cc_c;
      4'h6: cond_true = ~cc_z;
      4'h7: cond_true = cc_z;
      4'h8: cond_true = ~cc_v;
      4'h9: cond_true = cc_v;
      4'hA: cond_true = ~cc_n;
      4'hB: cond_true = cc_n;
      4'hC: cond_true = (cc_n == cc_v);
      4'hD: cond_true = (cc_n != cc_v);
      4'hE: cond_true = ~cc_z & (cc_n == cc_v);
      4'hF: cond_true = cc_z | (cc_n != cc_v);
      default: cond_true = 1'b0;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // Next-state and control-output decode
  always_comb begin
    state_d       = state_q;
    bus.ir_en     = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.reg_write = 1'b0;
    bus.dest      = 3'd0;
    bus.srcA      = 3'd0;
    bus.srcB      = 3'd0;
    bus.shift_op  = 2'b00;
    bus.opB_imm   = 1'b0;
    bus.imm16     = 16'h0000;
    bus.alu_func  = 3'd0;
    bus.cc_en     = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.addr_sel  = 1'b0;

    case (state_q)
      FETCH: begin
        bus.addr_sel = 1'b0;
        bus.mem_ren  = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_en  = 1'b1;
          bus.pc_inc = 1'b1;
          state_d    = EXECUTE;
        end
      end

      EXECUTE: begin
        bus.dest     = dec_dest;
        bus.srcA     = dec_srca;
        bus.srcB     = dec_srcb;
        bus.shift_op = dec_shift;
        bus.opB_imm  = dec_opb_imm;
        bus.imm16    = dec_imm16;
        bus.alu_func = op;
        if (op == OP_BRANCH) begin
          bus.reg_write = cond_true;
          state_d       = FETCH;
        end else if (op == OP_MEM) begin
          state_d = MEMORY;
        end else begin
          bus.reg_write = 1'b1;
          bus.cc_en     = s_bit;
          state_d       = FETCH;
        end
      end

      MEMORY: begin
        bus.dest     = dec_dest;
        bus.srcA     = dec_srca;
        bus.srcB     = dec_srcb;
        bus.shift_op = dec_shift;
        bus.opB_imm  = dec_opb_imm;
        bus.imm16    = dec_imm16;
        bus.alu_func = OP_MEM;
        bus.addr_sel = 1'b1;
        if (s_bit) begin
          // Store: data register travels on operand B
          bus.mem_wen = 1'b1;
          bus.srcB    = dec_dest;
        end else begin
          bus.mem_ren = 1'b1;
        end
        if (bus.mem_ready) begin
          bus.reg_write = ~s_bit;
          state_d       = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    // A reset cycle commits nothing, even mid-access
    if (!rst_n) begin
      bus.ir_en     = 1'b0;
      bus.pc_inc    = 1'b0;
      bus.reg_write = 1'b0;
      bus.cc_en     = 1'b0;
      bus.mem_wen   = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_stump_control_fsm.sv
// Directed bench for the Stump control sequencer.
module tb_stump_control_fsm;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  stump_control_fsm_if bus ();

  stump_control_fsm #(.RESET_STATE(2'b00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ir = 16'h0000;
    bus.cc = 4'h0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.state !== 2'b00) $display("FAIL reset_state: got %b want 00", bus.state);
    else passed++;
    total++;
    if ({bus.mem_ren, bus.addr_sel} !== 2'b10)
      $display("FAIL reset_fetch_strobes: got {ren,asel}=%b want 10", {bus.mem_ren, bus.addr_sel});
    else passed++;
    total++;
    if ({bus.reg_write, bus.mem_wen, bus.cc_en, bus.ir_en, bus.pc_inc} !== 5'b0)
      $display("FAIL reset_writes: got %b want 00000",
               {bus.reg_write, bus.mem_wen, bus.cc_en, bus.ir_en, bus.pc_inc});
    else passed++;
  endtask

  task automatic test_fetch_stall();
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if ({bus.ir_en, bus.pc_inc} !== 2'b00)
      $display("FAIL stall_enables: got %b want 00", {bus.ir_en, bus.pc_inc});
    else passed++;
    tick();
    total++;
    if (bus.state !== 2'b00) $display("FAIL stall_hold: got %b want 00", bus.state);
    else passed++;
  endtask

  task automatic test_alu();
    // ADDS R2,R2,#5
    bus.ir = 16'h1A45;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if ({bus.ir_en, bus.pc_inc, bus.mem_ren} !== 3'b111)
      $display("FAIL alu_fetch: got {ir_en,pc_inc,ren}=%b want 111", {bus.ir_en, bus.pc_inc, bus.mem_ren});
    else passed++;
    tick();
    total++;
    if (bus.state !== 2'b01) $display("FAIL alu_exec_state: got %b want 01", bus.state);
    else passed++;
    total++;
    if ({bus.alu_func, bus.reg_write, bus.cc_en, bus.dest, bus.srcA} !== {3'd0, 1'b1, 1'b1, 3'd2, 3'd2})
      $display("FAIL alu_imm_ctrl: got func=%0d rw=%b cce=%b dest=%0d srcA=%0d want 0 1 1 2 2",
               bus.alu_func, bus.reg_write, bus.cc_en, bus.dest, bus.srcA);
    else passed++;
    total++;
    if ({bus.opB_imm, bus.imm16, bus.shift_op} !== {1'b1, 16'h0005, 2'b00})
      $display("FAIL alu_imm_operand: got opB_imm=%b imm16=%h shift=%b want 1 0005 00",
               bus.opB_imm, bus.imm16, bus.shift_op);
    else passed++;
    tick();
    total++;
    if (bus.state !== 2'b00) $display("FAIL alu_return: got %b want 00", bus.state);
    else passed++;

    // Register form, no S: op 011 dest 5 srcA 3 srcB 4 shift 2
    bus.ir = 16'h6572;
    tick();
    total++;
    if ({bus.alu_func, bus.reg_write, bus.cc_en, bus.dest, bus.srcA, bus.srcB, bus.shift_op, bus.opB_imm}
        !== {3'd3, 1'b1, 1'b0, 3'd5, 3'd3, 3'd4, 2'd2, 1'b0})
      $display("FAIL alu_reg_ctrl: got func=%0d rw=%b cce=%b dest=%0d A=%0d B=%0d sh=%0d imm=%b want 3 1 0 5 3 4 2 0",
               bus.alu_func, bus.reg_write, bus.cc_en, bus.dest, bus.srcA, bus.srcB,
               bus.shift_op, bus.opB_imm);
    else passed++;
    tick();

    // Negative 5-bit immediate sign-extends: op 010 imm -1
    bus.ir = 16'h501F;
    tick();
    total++;
    if (bus.imm16 !== 16'hFFFF) $display("FAIL alu_sext5: got %h want FFFF", bus.imm16);
    else passed++;
    tick();
  endtask

  task automatic test_load();
    bus.ir = 16'hC0C3;
    bus.mem_ready = 1'b1;
    tick();
    total++;
    if ({bus.state, bus.alu_func, bus.reg_write, bus.cc_en} !== {2'b01, 3'b110, 1'b0, 1'b0})
      $display("FAIL ld_exec: got state=%b func=%b rw=%b cce=%b want 01 110 0 0",
               bus.state, bus.alu_func, bus.reg_write, bus.cc_en);
    else passed++;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) bus.mem_ready = 1'b1;
      #1;
      total++;
      if ({bus.state, bus.mem_ren, bus.mem_wen, bus.addr_sel, bus.reg_write, bus.dest, bus.srcA}
          !== {2'b10, 1'b1, 1'b0, 1'b1, (i == 2), 3'd0, 3'd6})
        $display("FAIL ld_mem_cycle%0d: got state=%b ren=%b wen=%b asel=%b rw=%b dest=%0d A=%0d want 10 1 0 1 %0d 0 6",
                 i, bus.state, bus.mem_ren, bus.mem_wen, bus.addr_sel, bus.reg_write, bus.dest,
                 bus.srcA, (i == 2));
      else passed++;
    end
    tick();
    total++;
    if (bus.state !== 2'b00) $display("FAIL ld_return: got %b want 00", bus.state);
    else passed++;
  endtask

  task automatic test_store();
    // ST R3, [R1, #2]
    bus.ir = 16'hDB22;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    total++;
    if ({bus.state, bus.mem_wen, bus.mem_ren, bus.reg_write, bus.srcB, bus.addr_sel, bus.alu_func}
        !== {2'b10, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 3'b110})
      $display("FAIL st_mem: got state=%b wen=%b ren=%b rw=%b B=%0d asel=%b func=%b want 10 1 0 0 3 1 110",
               bus.state, bus.mem_wen, bus.mem_ren, bus.reg_write, bus.srcB, bus.addr_sel, bus.alu_func);
    else passed++;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if ({bus.mem_wen, bus.reg_write, bus.cc_en} !== 3'b100)
      $display("FAIL st_complete: got {wen,rw,cce}=%b want 100", {bus.mem_wen, bus.reg_write, bus.cc_en});
    else passed++;
    tick();
    total++;
    if (bus.state !== 2'b00) $display("FAIL st_return: got %b want 00", bus.state);
    else passed++;
  endtask

  task automatic test_branch();
    logic [3:0] conds [12] = '{4'h7, 4'h7, 4'h0, 4'h1, 4'h2, 4'h3, 4'hC, 4'hD, 4'hE, 4'hF, 4'h9, 4'hB};
    logic [3:0] ccs   [12] = '{4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0001,
                               4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    logic       taken [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.ir = {3'b111, 1'b0, conds[i], 8'hFE};
      bus.cc = ccs[i];
      tick();
      total++;
      if ({bus.state, bus.reg_write, bus.dest, bus.srcA, bus.opB_imm, bus.imm16, bus.cc_en, bus.alu_func}
          !== {2'b01, taken[i], 3'd7, 3'd7, 1'b1, 16'hFFFE, 1'b0, 3'b111})
        $display("FAIL branch_cond%h_cc%b: got state=%b rw=%b dest=%0d A=%0d imm=%b imm16=%h cce=%b func=%b want 01 %b 7 7 1 fffe 0 111",
                 conds[i], ccs[i], bus.state, bus.reg_write, bus.dest, bus.srcA, bus.opB_imm,
                 bus.imm16, bus.cc_en, bus.alu_func, taken[i]);
      else passed++;
      tick();
    end
    total++;
    if (bus.state !== 2'b00) $display("FAIL branch_return: got %b want 00", bus.state);
    else passed++;
  endtask

  task automatic test_reset_in_memory();
    bus.ir = 16'hDB22;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    total++;
    if ({bus.state, bus.mem_wen} !== 3'b101)
      $display("FAIL rst_mem_setup: got state=%b wen=%b want 10 1", bus.state, bus.mem_wen);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.mem_wen, bus.reg_write} !== 2'b00)
      $display("FAIL rst_mem_gate: got {wen,rw}=%b want 00", {bus.mem_wen, bus.reg_write});
    else passed++;
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if ({bus.state, bus.mem_wen, bus.mem_ren} !== {2'b00, 1'b0, 1'b1})
      $display("FAIL rst_mem_abort: got state=%b wen=%b ren=%b want 00 0 1",
               bus.state, bus.mem_wen, bus.mem_ren);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_fetch_stall();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_reset_in_memory();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
